// File: rtl/elevator_scheduler.sv
// Purpose : SCAN dispatcher for a 3-floor car; picks direction, times travel/door, pulses latch clears.
// Latency : request at the current floor while idle -> door_open and clr pulse one cycle later.
// Backpres: none; requests are level-held by external latches until the matching clr pulse.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_car[2:0]        car buttons, bit i = floor i+1
//   req_up[1:0]         hall-up, bit0 = floor1, bit1 = floor2
//   req_down[1:0]       hall-down, bit0 = floor2, bit1 = floor3
//   floor_ind[2:0]      one-hot current floor
//   door_open           high while the door is open
//   moving_up/moving_dn high while travelling up/down
//   clr_car/up/down     one-cycle clear pulses back to the request latches
module elevator_scheduler #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_car,
    input  logic [1:0] req_up,
    input  logic [1:0] req_down,
    output logic [2:0] floor_ind,
    output logic       door_open,
    output logic       moving_up,
    output logic       moving_dn,
    output logic [2:0] clr_car,
    output logic [1:0] clr_up,
    output logic [1:0] clr_down
);

    typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR} state_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    state_t           state;
    logic             dir_up;
    logic [CNT_W-1:0] timer;

    // Hall calls re-indexed by floor so they line up with floor_ind.
    logic [2:0] hall_up_at;
    logic [2:0] hall_dn_at;
    logic [2:0] all_req;
    logic       above;
    logic       below;
    logic       ahead;
    logic [2:0] car_hit;
    logic [2:0] up_hit;
    logic [2:0] dn_hit;
    logic       serve;
    logic       flip;

    assign hall_up_at = {1'b0, req_up};
    assign hall_dn_at = {req_down, 1'b0};
    assign all_req    = req_car | hall_up_at | hall_dn_at;

    assign above = (floor_ind[0] & (|all_req[2:1])) | (floor_ind[1] & all_req[2]);
    assign below = (floor_ind[2] & (|all_req[1:0])) | (floor_ind[1] & all_req[0]);
    assign ahead = dir_up ? above : below;

    // Bits to clear at this floor. A hall call against the travel direction is
    // only taken when nothing lies ahead. Masking with the pulse already on the
    // wire keeps a slow latch from seeing a held clear.
    assign car_hit = req_car & floor_ind & ~clr_car;
    assign up_hit  = hall_up_at & floor_ind & {3{dir_up | ~ahead}} & ~{1'b0, clr_up};
    assign dn_hit  = hall_dn_at & floor_ind & {3{~dir_up | ~ahead}} & ~{clr_down, 1'b0};
    assign serve   = |{car_hit, up_hit, dn_hit};
    // Serving the opposite hall call means the car now leaves the other way.
    assign flip    = dir_up ? (|dn_hit) : (|up_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dir_up    <= 1'b1;
            timer     <= '0;
            floor_ind <= 3'b001;
            door_open <= 1'b0;
            moving_up <= 1'b0;
            moving_dn <= 1'b0;
            clr_car   <= '0;
            clr_up    <= '0;
            clr_down  <= '0;
        end else begin
            clr_car  <= '0;
            clr_up   <= '0;
            clr_down <= '0;
            case (state)
                S_IDLE: begin
                    if (serve) begin
                        state     <= S_DOOR;
                        door_open <= 1'b1;
                        timer     <= '0;
                        clr_car   <= car_hit;
                        clr_up    <= up_hit[1:0];
                        clr_down  <= dn_hit[2:1];
                        if (flip) dir_up <= ~dir_up;
                    end else if (above && (dir_up || !below)) begin
                        state     <= S_MOVE_UP;
                        moving_up <= 1'b1;
                        dir_up    <= 1'b1;
                        timer     <= '0;
                    end else if (below) begin
                        state     <= S_MOVE_DN;
                        moving_dn <= 1'b1;
                        dir_up    <= 1'b0;
                        timer     <= '0;
                    end
                end
                S_MOVE_UP: begin
                    if (timer == TRAVEL_LAST) begin
                        floor_ind <= {floor_ind[1:0], 1'b0};
                        state     <= S_IDLE;
                        moving_up <= 1'b0;
                        timer     <= '0;
                        // Arriving at the top floor: only way out is down.
                        if (floor_ind[1]) dir_up <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_MOVE_DN: begin
                    if (timer == TRAVEL_LAST) begin
                        floor_ind <= {1'b0, floor_ind[2:1]};
                        state     <= S_IDLE;
                        moving_dn <= 1'b0;
                        timer     <= '0;
                        // Arriving at the bottom floor: only way out is up.
                        if (floor_ind[1]) dir_up <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DOOR: begin
                    if (serve) begin
                        // Late arrival for this floor: clear it and hold the door again.
                        clr_car  <= car_hit;
                        clr_up   <= up_hit[1:0];
                        clr_down <= dn_hit[2:1];
                        timer    <= '0;
                        if (flip) dir_up <= ~dir_up;
                    end else if (timer == DOOR_LAST) begin
                        state     <= S_IDLE;
                        door_open <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
